// File: rtl/viterbi_decoder_if.sv
// -----------------------------------------------------------------------------
// viterbi_decoder_if
//   Symbol-in / bit-out bus of the K=3 rate-1/2 hard-decision Viterbi decoder.
//
//   sym_valid : sym is accepted on this clk_div2 edge when high (no backpressure)
//   sym[1:0]  : received code symbol, sym[1] = g0 bit, sym[0] = g1 bit
//   out_valid : single-cycle pulse, out_bit carries a decoded data bit
//   out_bit   : decoded data bit (holds between pulses)
//
//   master : symbol source (upstream deserializer / testbench)
//   slave  : the decoder
// -----------------------------------------------------------------------------
interface viterbi_decoder_if;
  logic       sym_valid;
  logic [1:0] sym;
  logic       out_valid;
  logic       out_bit;

  modport master (
    output sym_valid,
    output sym,
    input  out_valid,
    input  out_bit
  );

  modport slave (
    input  sym_valid,
    input  sym,
    output out_valid,
    output out_bit
  );
endinterface

// File: rtl/viterbi_decoder.sv
// -----------------------------------------------------------------------------
// viterbi_decoder
//   Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code
//   with generators g0=111, g1=101. One code symbol per accepted clk_div2
//   edge; one decoded bit per accept once TB_DEPTH symbols have been seen.
//
//   Architecture: 4-state add-compare-select array, path metrics normalised
//   to a minimum of zero on every update, register-exchange survivors.
//
// Parameters
//   TB_DEPTH : survivor length in symbols, equals the decode latency
//   METRIC_W : path metric width, must be >= 4
//
// Ports
//   clk_div2 : symbol clock, all logic on the rising edge
//   rst_n    : synchronous active-low reset, priority over sym_valid
//   bus      : viterbi_decoder_if.slave (sym_valid, sym, out_valid, out_bit)
//
// Trellis: state = {s1,s0} = {previous input, input before that}.
//   From {a,b}, input x goes to {x,a} and emits {x^a^b, x^b}.
//   State n = {x,a} therefore has predecessors {a,0} and {a,1}.
// -----------------------------------------------------------------------------
module viterbi_decoder #(
  parameter int TB_DEPTH = 15,
  parameter int METRIC_W = 6
) (
  input  logic               clk_div2,
  input  logic               rst_n,
  viterbi_decoder_if.slave   bus
);

  localparam int CNT_W = $clog2(TB_DEPTH + 1);
  localparam logic [CNT_W-1:0]    FILL_FULL = CNT_W'(TB_DEPTH);
  // Unreached states start far from state 00 so that the first few symbols
  // are decoded as if the encoder started in the all-zero state.
  localparam logic [METRIC_W-1:0] PM_INIT = {1'b1, {(METRIC_W-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [METRIC_W-1:0] pm_q [4];
  logic [TB_DEPTH-1:0] sv_q [4];
  logic [CNT_W-1:0]    fill_cnt_q;
  logic                out_valid_q;
  logic                out_bit_q;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // Expected code symbol leaving predecessor state `pred` with input x.
  function automatic logic [1:0] exp_sym(input logic [1:0] pred, input logic x);
    return {x ^ pred[1] ^ pred[0], x ^ pred[0]};
  endfunction

  // Hamming distance between two 2-bit symbols (0..2).
  function automatic logic [1:0] branch_metric(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] d;
    d = a ^ b;
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Add-compare-select, normalisation, survivor exchange, best state
  // ---------------------------------------------------------------------------
  logic [METRIC_W:0]   cand    [4][2];
  logic                sel     [4];
  logic [METRIC_W:0]   pm_acs  [4];
  logic [METRIC_W:0]   pm_min;
  logic [METRIC_W-1:0] pm_next [4];
  logic [TB_DEPTH-1:0] sv_next [4];
  logic [1:0]          best_state;

  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path through the block leaves a latch behind.
    pm_min     = '1;
    best_state = 2'd0;
    for (int n = 0; n < 4; n++) begin
      cand[n][0] = '0;
      cand[n][1] = '0;
      sel[n]     = 1'b0;
      pm_acs[n]  = '0;
      pm_next[n] = '0;
      sv_next[n] = '0;
    end

    // ACS: predecessor b lives at index {n[0], b}; input bit x is n[1].
    for (int n = 0; n < 4; n++) begin
      for (int b = 0; b < 2; b++) begin
        cand[n][b] = {1'b0, pm_q[2*(n%2)+b]}
                   + (METRIC_W+1)'(branch_metric(bus.sym, exp_sym(2'(2*(n%2)+b), n[1])));
      end
      // Strict less-than: on a tie the b=0 predecessor wins.
      sel[n]    = (cand[n][1] < cand[n][0]);
      pm_acs[n] = sel[n] ? cand[n][1] : cand[n][0];
    end

    for (int n = 0; n < 4; n++) begin
      if (pm_acs[n] < pm_min) pm_min = pm_acs[n];
    end

    // After subtracting the minimum every metric fits back into METRIC_W bits.
    for (int n = 0; n < 4; n++) begin
      pm_next[n] = METRIC_W'(pm_acs[n] - pm_min);
      sv_next[n] = {sv_q[2*(n%2) + (sel[n] ? 1 : 0)][TB_DEPTH-2:0], n[1]};
    end

    // Lowest index with a zero stored metric; scan downwards so index 0 wins.
    for (int n = 3; n >= 0; n--) begin
      if (pm_q[n] == '0) best_state = 2'(n);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_div2) begin
    if (!rst_n) begin
      // NOTE: the metric and survivor arrays are reset explicitly because a
      // mid-stream reset must discard all history, not just the counters.
      for (int n = 0; n < 4; n++) begin
        pm_q[n] <= (n == 0) ? '0 : PM_INIT;
        sv_q[n] <= '0;
      end
      fill_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
    end else if (bus.sym_valid) begin
      // NOTE: state updates use non-blocking assignments, so the output path
      // below reads the pre-update survivors and metrics of this same edge.
      for (int n = 0; n < 4; n++) begin
        pm_q[n] <= pm_next[n];
        sv_q[n] <= sv_next[n];
      end
      if (fill_cnt_q != FILL_FULL) fill_cnt_q <= fill_cnt_q + 1'b1;
      out_valid_q <= (fill_cnt_q == FILL_FULL);
      if (fill_cnt_q == FILL_FULL) out_bit_q <= sv_q[best_state][TB_DEPTH-1];
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_bit   = out_bit_q;

endmodule

// File: tb/tb_viterbi_decoder.sv
// -----------------------------------------------------------------------------
// tb_viterbi_decoder
//   Directed bench for viterbi_decoder (TB_DEPTH=15, METRIC_W=6).
//   Expected decoded bits are the transmitted data delayed by TB_DEPTH
//   accepts; symbols come from a hand table or a small encoder model.
// -----------------------------------------------------------------------------
module tb_viterbi_decoder;

  localparam int TB_DEPTH = 15;
  localparam int METRIC_W = 6;

  localparam logic [1:0] T2_SYM  [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
  localparam logic       T2_DATA [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  logic clk_div2 = 1'b0;
  logic rst_n    = 1'b0;

  viterbi_decoder_if bus ();

  viterbi_decoder #(
    .TB_DEPTH (TB_DEPTH),
    .METRIC_W (METRIC_W)
  ) dut (
    .clk_div2 (clk_div2),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 clk_div2 = ~clk_div2;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] sym_tab  [256];
  logic       data_tab [256];
  int         acc_cnt;
  int         pulse_cnt;
  logic       last_exp;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int min_pm();
    int m;
    m = int'(dut.pm_q[0]);
    for (int i = 1; i < 4; i++) if (int'(dut.pm_q[i]) < m) m = int'(dut.pm_q[i]);
    return m;
  endfunction

  // Reset with sym_valid held high to confirm reset wins.
  task automatic do_reset(input string tag);
    rst_n         = 1'b0;
    bus.sym_valid = 1'b1;
    bus.sym       = 2'b11;
    @(posedge clk_div2); #1;
    check({tag, "_rst_valid"}, int'(bus.out_valid), 0);
    check({tag, "_rst_bit"},   int'(bus.out_bit), 0);
    check({tag, "_rst_pm0"},   int'(dut.pm_q[0]), 0);
    check({tag, "_rst_pm3"},   int'(dut.pm_q[3]), 32);
    rst_n         = 1'b1;
    bus.sym_valid = 1'b0;
    acc_cnt       = 0;
    pulse_cnt     = 0;
    last_exp      = 1'b0;
  endtask

  task automatic fill_data_zero();
    for (int i = 0; i < 256; i++) data_tab[i] = 1'b0;
  endtask

  // Reference rate-1/2 K=3 encoder: fills sym_tab from data_tab.
  task automatic encode(input int n);
    logic s1, s0, x;
    s1 = 1'b0;
    s0 = 1'b0;
    for (int i = 0; i < n; i++) begin
      x          = data_tab[i];
      sym_tab[i] = {x ^ s1 ^ s0, x ^ s0};
      s0         = s1;
      s1         = x;
    end
  endtask

  task automatic load_test2();
    fill_data_zero();
    for (int i = 0; i < 256; i++) sym_tab[i] = 2'b00;
    for (int i = 0; i < 6; i++) begin
      data_tab[i] = T2_DATA[i];
      sym_tab[i]  = T2_SYM[i];
    end
  endtask

  // One clk_div2 edge; outputs sampled 1 time unit after it.
  task automatic step(input string tag, input logic valid, input logic [1:0] s);
    int idx;
    bus.sym_valid = valid;
    bus.sym       = s;
    @(posedge clk_div2); #1;
    if (bus.out_valid) pulse_cnt++;
    if (valid) begin
      idx = acc_cnt;
      acc_cnt++;
      if (idx >= TB_DEPTH) begin
        last_exp = data_tab[idx-TB_DEPTH];
        check($sformatf("%s_valid_%0d", tag, idx), int'(bus.out_valid), 1);
        check($sformatf("%s_bit_%0d", tag, idx), int'(bus.out_bit), int'(last_exp));
      end else begin
        check($sformatf("%s_early_%0d", tag, idx), int'(bus.out_valid), 0);
      end
      check($sformatf("%s_minpm_%0d", tag, idx), min_pm(), 0);
    end else begin
      check($sformatf("%s_gapvalid_%0d", tag, acc_cnt), int'(bus.out_valid), 0);
      check($sformatf("%s_gaphold_%0d", tag, acc_cnt), int'(bus.out_bit), int'(last_exp));
    end
    bus.sym_valid = 1'b0;
  endtask

  task automatic run(input string tag, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      step(tag, 1'b1, sym_tab[i]);
      for (int g = 0; g < gap; g++) step(tag, 1'b0, 2'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    bus.sym_valid = 1'b0;
    bus.sym       = 2'b00;
    repeat (2) @(posedge clk_div2);

    // 1: all-zero stream
    do_reset("t1");
    fill_data_zero();
    encode(40);
    run("t1", 40, 0);
    check("t1_pulses", pulse_cnt, 40 - TB_DEPTH);

    // 2: clean sequence 1,0,1,1,0,0 plus zero tail
    do_reset("t2");
    load_test2();
    run("t2", 30, 0);

    // 3: single symbol error at index 2 (00 -> 10)
    do_reset("t3");
    load_test2();
    sym_tab[2] = 2'b10;
    run("t3", 30, 0);

    // 4: three idle cycles after every accept
    do_reset("t4");
    load_test2();
    run("t4", 30, 3);
    check("t4_pulses", pulse_cnt, 30 - TB_DEPTH);

    // 5: reset after 10 symbols, then full replay
    do_reset("t5a");
    load_test2();
    run("t5a", 10, 0);
    do_reset("t5b");
    run("t5b", 30, 0);
    check("t5_pulses", pulse_cnt, 30 - TB_DEPTH);

    // 6: alternating 1,0 x30 plus zero tail
    do_reset("t6");
    fill_data_zero();
    for (int i = 0; i < 60; i++) data_tab[i] = (i % 2 == 0);
    encode(77);
    run("t6", 77, 0);
    check("t6_pulses", pulse_cnt, 77 - TB_DEPTH);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/viterbi_decoder.md
Name: viterbi_decoder

Overview:
- Hard-decision Viterbi decoder for the team's rate-1/2, K=3 convolutional code (generators g0=111, g1=101).
- Consumes one 2-bit code symbol per clk_div2 cycle from the upstream deserializer that de-interleaves the encoder's serial stream.
- Emits the decoded data bit after a fixed traceback delay.
- Uses a 4-state add-compare-select (ACS) array, min-normalized path metrics and register-exchange survivor memory.

Parameters:
- TB_DEPTH, 15: survivor register length in symbols; decode latency.
- METRIC_W, 6: path metric width in bits; must be >= 4.

Ports:
- clk_div2  in  1  symbol clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- sym_valid  in  1  sym is accepted on this edge when high; no backpressure.
- sym  in  2  received code symbol; sym[1] = g0 bit (x^s1^s0), sym[0] = g1 bit (x^s0).
- out_valid  out  1  out_bit is valid; single-cycle pulse per decoded bit.
- out_bit  out  1  decoded data bit.

Behaviour:
- Trellis:
  - State index = {s1,s0} = {previous input, input before that}.
  - From state {a,b}, input x goes to next state {x,a} with expected symbol {x^a^b, x^b}.
  - Each state n={x,a} has two predecessors, {a,0} and {a,1}.
- Branch metric: Hamming distance between sym and the expected symbol, range 0..2, 2 bits.
- ACS on each accepted symbol:
  - cand_b = PM[{a,b}] + BM for b in {0,1}.
  - New PM[n] = min of the two candidates.
  - Tie: select the predecessor with b=0.
- Normalization, same edge as ACS:
  - Subtract the minimum of the four new metrics from all four.
  - The stored minimum is always 0; the spread never exceeds 4, so no saturation logic is needed.
  - Use METRIC_W+1-bit intermediates.
- Survivors:
  - SV[state] holds TB_DEPTH bits; bit 0 is newest.
  - New SV[n] = {SV[selected predecessor][TB_DEPTH-2:0], x}, where x = n[1].
- Best state:
  - Lowest-index state whose stored PM equals 0.
  - Computed combinationally from pre-update registers.
- Output, registered:
  - On an accept edge, if fill_cnt == TB_DEPTH, set out_valid=1 and out_bit = SV[best][TB_DEPTH-1], using pre-update values.
  - Otherwise out_valid=0.
  - The bit produced on the edge accepting symbol n (0-based) estimates the input of symbol n-TB_DEPTH.
  - First out_valid is at the accept edge of symbol index TB_DEPTH.
- fill_cnt:
  - Range 0..TB_DEPTH; increments per accept and saturates at TB_DEPTH.
  - Width is ceil(log2(TB_DEPTH+1)).
- sym_valid low:
  - PM, SV and fill_cnt hold.
  - out_valid=0 next edge; out_bit holds its last value.
- Reset, when rst_n is low on a clk_div2 edge:
  - PM[0]=0, PM[1..3]=2^(METRIC_W-1).
  - All SV=0, fill_cnt=0, out_valid=0, out_bit=0.
  - Reset has priority over sym_valid.
  - Reset mid-stream discards all history; the next accepted symbol is treated as symbol 0 from state 00.
- No flush input: the upstream framer appends TB_DEPTH+2 zero tail bits to flush the last data bits.

Test Plan:
1. Zero stream: reset, then 40 accepted symbols of 00.
   - out_valid first high at the accept edge of symbol 15.
   - out_valid high on every subsequent accept; out_bit always 0.
2. Clean sequence: data 1,0,1,1,0,0, then zero tail, giving symbols 11,10,00,01,01,11,00...
   - out_bits 1,0,1,1,0,0,0... starting at the accept edge of symbol 15.
3. Single error: same as test 2 with the symbol at index 2 corrupted 00 -> 10.
   - Identical out_bit sequence to test 2.
   - Metrics stay in range; min stored PM = 0 every cycle.
4. Valid gaps: test 2 with sym_valid low for 3 cycles after every accepted symbol.
   - Same decoded sequence.
   - out_valid pulses only on accept edges; the count of out_valid pulses equals accepts minus 15.
5. Reset mid-stream: rst_n low for one edge after 10 symbols of test 2, then test 2 replayed.
   - No out_valid before the 16th post-reset accept.
   - Decoded output matches test 2.
6. Alternating data: 1,0 repeated 30 times.
   - Decoded stream reproduces 1,0,1,0... with latency 15 and no errors.
   - Tie-break determinism checked against a reference model.
